mac_datapath: RTL
=================

// Module: mac_datapath
// PURPOSE
//  Multiply-accumulate datapath answering the MAC controller's handshakes (rd/mul_valid/add_valid ->
//  mul_done/add_done). Captures one FIFO sample and per-term coefficients. Signed sequential
//  multiply, saturating accumulate, result publish on load_result_i. Sits between MAC controller, sample FIFO and coeff ROM.
// PARAMETERS
//  DATA_W  16  signed sample/coefficient width (>=2)
//  ACC_W   40  signed accumulator/result width (>= 2*DATA_W)
// PORTS
//  clk_i           in   1        clock, all flops posedge
//  rst_i           in   1        async reset, active-high
//  dp_reset_i      in   1        sync clear: acc, product, flags; aborts multiply
//  rd_signal_i     in   1        FIFO read strobe; sample_i valid next cycle
//  sample_i        in   DATA_W   FIFO read data (signed)
//  rd_coeff_i      in   1        ROM read strobe; coeff_i valid next cycle
//  coeff_i         in   DATA_W   ROM read data (signed)
//  mul_valid_i     in   1        start multiply pulse
//  add_valid_i     in   1        start accumulate pulse
//  load_result_i   in   1        publish accumulator
//  mul_done_o      out  1        1-cycle pulse, product ready
//  add_done_o      out  1        1-cycle pulse, accumulate done
//  result_o        out  ACC_W    published result (held)
//  result_valid_o  out  1        1-cycle pulse, cycle after load_result_i
//  sat_o           out  1        sticky: accumulate saturated since last dp_reset_i
//  proto_err_o     out  1        sticky: handshake violation since last dp_reset_i
// BEHAVIOUR
//  Reset (rst_i): all outputs, sample_q, coeff_q, product, acc = 0; FSM M_IDLE. Async, any cycle, aborts all.
//  Capture: rd_signal_i registered -> next cycle sample_q <= sample_i. Same for rd_coeff_i/coeff_q.
//  Operand bypass: on mul_valid_i, coefficient = (rd_coeff_q ? coeff_i : coeff_q); sample = sample_q
//   (rd_signal_i leads mul_valid_i by >=2 cycles, so sample_q is already valid).
//  Multiplier FSM:
//   M_IDLE -mul_valid_i-> M_SHIFT: latch |a|,|b|, sign=a^b; partial=0; cnt=0.
//   M_SHIFT: add |a|<<cnt to partial if bit cnt of |b| set; cnt++; after DATA_W iterations -> M_SIGN.
//   M_SIGN: product <= sign ? -partial : partial (2*DATA_W signed); mul_done_o=1 -> M_IDLE.
//   Latency: mul_valid_i in cycle t -> mul_done_o high in cycle t+DATA_W+1; product valid same cycle.
//   (-2^(W-1))^2 = 2^(2W-2) representable; no overflow possible.
//  Accumulate: add_valid_i in cycle t -> acc <= sat(acc + sext(product)) at end of t; add_done_o high in t+1.
//   Saturate to +(2^(ACC_W-1)-1) / -2^(ACC_W-1); set sat_o when clamped.
//  Publish: load_result_i in t -> result_o <= acc, result_valid_o=1 in t+1. result_o held otherwise.
//   load_result_i with add_valid_i same cycle: publishes pre-add acc; flag proto_err_o.
//  dp_reset_i: acc, product, sat_o, proto_err_o <= 0; multiplier -> M_IDLE, no mul_done_o. Pending done pulses suppressed.
//   result_o NOT cleared (last result stays readable).
//   dp_reset_i wins over mul_valid_i/add_valid_i same cycle (both ignored).
//  Violations (set proto_err_o, no other effect): mul_valid_i while not M_IDLE (ignored);
//   add_valid_i while not M_IDLE (add still performed with current product register).
//  Accumulator never wraps; sticky flags clear only via dp_reset_i or rst_i.
// TESTING
//  T1 DATA_W=16: sample 3, coeff -5, mul_valid at t -> mul_done at t+17, product -15; add -> acc -15.
//  T2 3-term MAC (2*4, -1*7, 6*6) with dp_reset first, load_result -> result_o 37, result_valid 1 cycle.
//  T3 ACC_W=32: product 0x3FFF0001 (0x7FFF*0x7FFF) added 3x -> 0x7FFE0002 then 0x7FFFFFFF, sat_o=1.
//  T4 sample=coeff=-32768 -> product 0x40000000; coeff via bypass (rd_coeff one cycle before mul_valid).
//  T5 rst_i asserted mid-M_SHIFT (cnt=7) -> all outputs 0 immediately, no mul_done after release.
//  T6 mul_valid during M_SHIFT -> ignored, proto_err_o=1, done still at original t+17; dp_reset clears flag.

Source files
------------

// File: rtl/mac_datapath.sv
// Multiply-accumulate datapath: operand capture from sample FIFO / coefficient ROM, signed
// shift-add multiplier, saturating accumulator and result publish for the MAC controller.
module mac_datapath #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     dp_reset_i,
    input  logic                     rd_signal_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic                     rd_coeff_i,
    input  logic signed [DATA_W-1:0] coeff_i,
    input  logic                     mul_valid_i,
    input  logic                     add_valid_i,
    input  logic                     load_result_i,
    output logic                     mul_done_o,
    output logic                     add_done_o,
    output logic signed [ACC_W-1:0]  result_o,
    output logic                     result_valid_o,
    output logic                     sat_o,
    output logic                     proto_err_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_SHIFT = 2'd1;
    localparam logic [1:0] M_SIGN  = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // |v| as an unsigned value; the most negative input maps to 2^(DATA_W-1), which still fits.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = v;
        return v[DATA_W-1] ? (~u + DATA_W'(1)) : u;
    endfunction

    function automatic logic overflowed(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
        if (overflowed(s)) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    logic                     rd_q;
    logic                     rd_coeff_q;
    logic signed [DATA_W-1:0] sample_q;
    logic signed [DATA_W-1:0] coeff_q;
    logic signed [DATA_W-1:0] coeff_op;

    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic [PROD_W-1:0]        mag_a;
    logic [DATA_W-1:0]        mag_b;
    logic                     neg;
    logic [PROD_W-1:0]        partial;
    logic [PROD_W-1:0]        partial_next;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] product_next;
    logic                     busy;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    acc_sum;

    // Coefficient read issued the cycle before the multiply is taken straight off the ROM bus.
    assign coeff_op = rd_coeff_q ? coeff_i : coeff_q;
    assign busy     = (state != M_IDLE);

    assign partial_next = partial + (mag_b[0] ? mag_a : '0);
    assign product_next = neg ? $signed(~partial_next + PROD_W'(1)) : $signed(partial_next);

    assign acc_sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q       <= 1'b0;
            rd_coeff_q <= 1'b0;
            sample_q   <= '0;
            coeff_q    <= '0;
        end else begin
            rd_q       <= rd_signal_i;
            rd_coeff_q <= rd_coeff_i;
            if (rd_q) begin
                sample_q <= sample_i;
            end
            if (rd_coeff_q) begin
                coeff_q <= coeff_i;
            end
        end
    end

    // Shift-add multiplier: one bit of |b| per cycle, |a| shifted left alongside.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= M_IDLE;
            cnt        <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            neg        <= 1'b0;
            partial    <= '0;
            product    <= '0;
            mul_done_o <= 1'b0;
        end else if (dp_reset_i) begin
            state      <= M_IDLE;
            product    <= '0;
            mul_done_o <= 1'b0;
        end else begin
            mul_done_o <= 1'b0;
            case (state)
                M_IDLE: begin
                    if (mul_valid_i) begin
                        state   <= M_SHIFT;
                        mag_a   <= PROD_W'(magnitude(sample_q));
                        mag_b   <= magnitude(coeff_op);
                        neg     <= sample_q[DATA_W-1] ^ coeff_op[DATA_W-1];
                        partial <= '0;
                        cnt     <= '0;
                    end
                end
                M_SHIFT: begin
                    partial <= partial_next;
                    mag_a   <= mag_a << 1;
                    mag_b   <= mag_b >> 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state      <= M_SIGN;
                        product    <= product_next;
                        mul_done_o <= 1'b1;
                    end
                end
                M_SIGN: begin
                    state <= M_IDLE;
                end
                default: begin
                    state <= M_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc        <= '0;
            add_done_o <= 1'b0;
            sat_o      <= 1'b0;
        end else if (dp_reset_i) begin
            acc        <= '0;
            add_done_o <= 1'b0;
            sat_o      <= 1'b0;
        end else begin
            add_done_o <= add_valid_i;
            if (add_valid_i) begin
                acc <= saturate(acc_sum);
                if (overflowed(acc_sum)) begin
                    sat_o <= 1'b1;
                end
            end
        end
    end

    // Publish is independent of dp_reset_i so the last result stays readable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= load_result_i;
            if (load_result_i) begin
                result_o <= acc;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            proto_err_o <= 1'b0;
        end else if (dp_reset_i) begin
            proto_err_o <= 1'b0;
        end else if ((mul_valid_i && busy) || (add_valid_i && busy) ||
                     (add_valid_i && load_result_i)) begin
            proto_err_o <= 1'b1;
        end
    end

endmodule
